// File: rtl/wb_uart_tx_if.sv
// rtl/wb_uart_tx_if.sv - Wishbone slave bundle for the UART transmitter
// Purpose: groups the classic Wishbone request/response signals so the bus
//          side of wb_uart_tx travels as one port.
// Signals:
//   i_wb_adr  [3:0]   byte address, [3:2] selects the register
//   i_wb_dat  [31:0]  write data
//   i_wb_sel  [3:0]   byte selects
//   i_wb_we           write enable
//   i_wb_cyc          bus cycle
//   i_wb_stb          strobe
//   o_wb_rdt  [31:0]  read data, valid while o_wb_ack is high
//   o_wb_ack          single-cycle acknowledge
// Modports: master drives the i_wb_* side, slave drives the o_wb_* side.
interface wb_uart_tx_if;
    logic [3:0]  i_wb_adr;
    logic [31:0] i_wb_dat;
    logic [3:0]  i_wb_sel;
    logic        i_wb_we;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;

    modport master (
        output i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb,
        input  o_wb_rdt, o_wb_ack
    );

    modport slave (
        input  i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb,
        output o_wb_rdt, o_wb_ack
    );
endinterface

// File: rtl/wb_uart_tx.sv
// rtl/wb_uart_tx.sv - Wishbone UART transmitter with byte FIFO, 8N1 framing
// Purpose: firmware pushes console bytes over Wishbone; they are queued in a
//          small FIFO and serialised LSB first with one start and one stop bit.
// Ports:
//   clk        system clock
//   rstn       asynchronous active-low reset
//   wb         Wishbone slave bundle (wb_uart_tx_if.slave)
//   o_uart_tx  serial line, idles high
//   o_irq      level interrupt: IRQ_EN & FIFO empty & transmitter idle
// Registers: 0x0 TXDATA (W), 0x4 STATUS (R, bit3 W1C), 0x8 CTRL (R/W).
module wb_uart_tx #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic            clk,
    input  logic            rstn,
    wb_uart_tx_if.slave     wb,
    output logic            o_uart_tx,
    output logic            o_irq
);

    localparam int DIV = CLK_FREQ_HZ / BAUD;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int BW  = $clog2(DIV);

    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // Bus side
    logic          ack_q, ack_d;
    logic [31:0]   rdt_q, rdt_d;
    logic          irq_q, irq_d;
    logic          irq_en_q, irq_en_d;
    logic          ovf_q, ovf_d;

    // FIFO
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Transmitter
    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    logic          wb_req, wb_wr, wb_rd;
    logic [1:0]    reg_idx;
    logic          fifo_full, fifo_empty;
    logic          push_req, push, pop;
    logic          ovf_clr, ctrl_wr;
    logic          baud_end;
    logic [7:0]    fifo_head;
    logic [31:0]   status_w;
    logic          unused_bits;

    // A new access is only taken while ack is low, so a held strobe is
    // acknowledged every second cycle and each access acts exactly once.
    assign wb_req   = wb.i_wb_cyc & wb.i_wb_stb & ~ack_q;
    assign wb_wr    = wb_req & wb.i_wb_we;
    assign wb_rd    = wb_req & ~wb.i_wb_we;
    assign reg_idx  = wb.i_wb_adr[3:2];

    assign fifo_full  = (count_q == DEPTH_C);
    assign fifo_empty = (count_q == '0);
    assign fifo_head  = mem_q[rd_ptr_q];

    // Fullness is judged on the pre-pop count: a push while full is dropped
    // even if the transmitter pops in the same cycle.
    assign push_req = wb_wr & (reg_idx == 2'd0) & wb.i_wb_sel[0];
    assign push     = push_req & ~fifo_full;
    assign ovf_clr  = wb_wr & (reg_idx == 2'd1) & wb.i_wb_sel[0] & wb.i_wb_dat[3];
    assign ctrl_wr  = wb_wr & (reg_idx == 2'd2) & wb.i_wb_sel[0];

    assign baud_end = (baud_q == BAUD_LAST);

    assign unused_bits = ^{wb.i_wb_dat[31:8], wb.i_wb_adr[1:0], wb.i_wb_sel[3:1]};

    always_comb begin
        status_w            = '0;
        status_w[0]         = fifo_full;
        status_w[1]         = fifo_empty;
        status_w[2]         = (state_q != S_IDLE);
        status_w[3]         = ovf_q;
        status_w[8 +: CW]   = count_q;
    end

    // Register file, acknowledge and interrupt
    always_comb begin
        ack_d    = wb_req;
        rdt_d    = '0;
        irq_en_d = irq_en_q;
        ovf_d    = ovf_q;
        if (wb_rd) begin
            case (reg_idx)
                2'd1:    rdt_d = status_w;
                2'd2:    rdt_d = {31'b0, irq_en_q};
                default: rdt_d = '0;
            endcase
        end
        if (ctrl_wr) begin
            irq_en_d = wb.i_wb_dat[0];
        end
        if (push_req && fifo_full) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        irq_d = irq_en_q & fifo_empty & (state_q == S_IDLE);
    end

    // FIFO pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Transmit FSM: every start, data and stop bit lasts DIV cycles; the baud
    // counter restarts from zero whenever the state or bit index changes.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_head;
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Chain straight into the next start bit so back-to-back
                    // bytes leave no idle gap on the line.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_head;
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                baud_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ack_q    <= 1'b0;
            rdt_q    <= '0;
            irq_q    <= 1'b0;
            irq_en_q <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
        end else begin
            ack_q    <= ack_d;
            rdt_q    <= rdt_d;
            irq_q    <= irq_d;
            irq_en_q <= irq_en_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
        end
    end

    // Storage needs no reset: occupancy is governed by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wb.i_wb_dat[7:0];
        end
    end

    assign wb.o_wb_ack = ack_q;
    assign wb.o_wb_rdt = rdt_q;
    assign o_uart_tx   = tx_q;
    assign o_irq       = irq_q;

endmodule

// File: tb/tb_wb_uart_tx.sv
// tb/tb_wb_uart_tx.sv - directed and randomized bench for wb_uart_tx
module tb_wb_uart_tx;

    localparam int CLK_HZ = 50_000_000;
    localparam int BAUD_R = 115200;
    localparam int DEPTH  = 8;
    localparam int DIV    = CLK_HZ / BAUD_R;
    localparam int FRAME  = 10 * DIV;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic uart_tx;
    logic irq;

    always #5 clk = ~clk;

    wb_uart_tx_if wbif ();

    wb_uart_tx #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD        (BAUD_R),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .wb        (wbif),
        .o_uart_tx (uart_tx),
        .o_irq     (irq)
    );

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Reference line model: fn frames sent back to back starting at offset 0.
    logic [7:0] fb [0:15];
    int         fn = 0;
    logic [7:0] dec_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc_n < t) tick();
    endtask

    function automatic logic line_at(input int off);
        int fr;
        int b;
        if (off < 0) return 1'b1;
        fr = off / FRAME;
        if (fr >= fn) return 1'b1;
        b = (off % FRAME) / DIV;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return fb[fr][b-1];
    endfunction

    function automatic logic [31:0] status_of(input int cnt, input logic busy, input logic ovf);
        return (32'(cnt) << 8) | (32'(ovf) << 3) | (32'(busy) << 2)
             | (32'(cnt == 0) << 1) | 32'(cnt == DEPTH);
    endfunction

    task automatic wb_write(input logic [3:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, output int ack_at);
        logic got;
        got = 1'b0;
        ack_at = -1;
        wbif.i_wb_adr = adr;
        wbif.i_wb_dat = dat;
        wbif.i_wb_sel = sel;
        wbif.i_wb_we  = 1'b1;
        wbif.i_wb_cyc = 1'b1;
        wbif.i_wb_stb = 1'b1;
        for (int i = 0; i < 16 && !got; i++) begin
            tick();
            if (wbif.o_wb_ack) begin
                got = 1'b1;
                ack_at = cyc_n;
            end
        end
        wbif.i_wb_cyc = 1'b0;
        wbif.i_wb_stb = 1'b0;
        wbif.i_wb_we  = 1'b0;
        chk("wr_ack_seen", 32'(got), 32'd1);
    endtask

    task automatic wb_read(input logic [3:0] adr, output logic [31:0] dat);
        logic got;
        got = 1'b0;
        dat = 'x;
        wbif.i_wb_adr = adr;
        wbif.i_wb_sel = 4'hf;
        wbif.i_wb_we  = 1'b0;
        wbif.i_wb_cyc = 1'b1;
        wbif.i_wb_stb = 1'b1;
        for (int i = 0; i < 16 && !got; i++) begin
            tick();
            if (wbif.o_wb_ack) begin
                got = 1'b1;
                dat = wbif.o_wb_rdt;
            end
        end
        wbif.i_wb_cyc = 1'b0;
        wbif.i_wb_stb = 1'b0;
        chk("rd_ack_seen", 32'(got), 32'd1);
    endtask

    // Line decoder: samples the middle of each bit after a falling edge.
    initial begin
        logic       prev;
        logic [7:0] b;
        prev = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rstn && prev && !uart_tx) begin
                repeat (DIV / 2) begin @(posedge clk); #1; end
                if (!uart_tx) begin
                    for (int k = 0; k < 8; k++) begin
                        repeat (DIV) begin @(posedge clk); #1; end
                        b[k] = uart_tx;
                    end
                    repeat (DIV) begin @(posedge clk); #1; end
                    if (uart_tx) begin
                        dec_q.push_back(b);
                        $display("decoder: 0x%02h '%c'", b, b);
                    end
                end
            end
            prev = uart_tx;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          e;
        int          f;
        int          pos;
        int          base;
        int          ack_c [10];
        logic [7:0]  bb [10];
        int          low_cnt;

        wbif.i_wb_adr = '0;
        wbif.i_wb_dat = '0;
        wbif.i_wb_sel = '0;
        wbif.i_wb_we  = 1'b0;
        wbif.i_wb_cyc = 1'b0;
        wbif.i_wb_stb = 1'b0;

        // Reset state
        tick(3);
        chk("rst_tx", 32'(uart_tx), 32'd1);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_ack", 32'(wbif.o_wb_ack), 32'd0);
        chk("rst_rdt", wbif.o_wb_rdt, 32'd0);
        rstn = 1'b1;
        tick(2);
        chk("post_rst_tx", 32'(uart_tx), 32'd1);
        chk("post_rst_irq", 32'(irq), 32'd0);
        wb_read(4'h4, rd); chk("rst_status", rd, status_of(0, 1'b0, 1'b0));
        wb_read(4'h8, rd); chk("rst_ctrl", rd, 32'd0);
        wb_read(4'h0, rd); chk("txdata_read", rd, 32'd0);
        wb_read(4'hc, rd); chk("unmapped_read", rd, 32'd0);
        wb_write(4'hc, 32'hffff_ffff, 4'hf, e);
        wb_read(4'h4, rd); chk("unmapped_write_ignored", rd, status_of(0, 1'b0, 1'b0));

        // Single byte 0x55
        fn = 1;
        fb[0] = 8'h55;
        dec_q.delete();
        wb_write(4'h0, 32'h55, 4'h1, e);
        chk("single_tx_at_ack", 32'(uart_tx), 32'd1);
        f = e + 1;
        for (int k = 0; k < 10; k++) begin
            wait_cyc(f + k * DIV);
            chk($sformatf("single_bit%0d_first", k), 32'(uart_tx), 32'(line_at(k * DIV)));
            wait_cyc(f + k * DIV + DIV - 1);
            chk($sformatf("single_bit%0d_last", k), 32'(uart_tx), 32'(line_at(k * DIV + DIV - 1)));
        end
        wait_cyc(f + FRAME);
        chk("single_idle_tx", 32'(uart_tx), 32'd1);
        tick(3);
        wb_read(4'h4, rd); chk("single_status_idle", rd, status_of(0, 1'b0, 1'b0));
        chk("single_dec_count", 32'(dec_q.size()), 32'd1);
        if (dec_q.size() > 0) chk("single_dec_byte", 32'(dec_q[0]), 32'h55);

        // Burst of 10 random bytes with strobe held
        dec_q.delete();
        for (int i = 0; i < 10; i++) bb[i] = 8'($urandom);
        fn = 9;
        for (int i = 0; i < 9; i++) fb[i] = bb[i];
        wbif.i_wb_adr = 4'h0;
        wbif.i_wb_sel = 4'h1;
        wbif.i_wb_we  = 1'b1;
        wbif.i_wb_dat = 32'(bb[0]);
        wbif.i_wb_cyc = 1'b1;
        wbif.i_wb_stb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            logic got;
            got = 1'b0;
            ack_c[i] = -1;
            for (int w = 0; w < 16 && !got; w++) begin
                tick();
                if (wbif.o_wb_ack) begin
                    got = 1'b1;
                    ack_c[i] = cyc_n;
                end
            end
            chk("burst_ack_seen", 32'(got), 32'd1);
            if (i < 9) wbif.i_wb_dat = 32'(bb[i+1]);
        end
        wbif.i_wb_cyc = 1'b0;
        wbif.i_wb_stb = 1'b0;
        wbif.i_wb_we  = 1'b0;
        for (int i = 1; i < 10; i++)
            chk($sformatf("burst_ack_spacing%0d", i), 32'(ack_c[i] - ack_c[i-1]), 32'd2);
        f = ack_c[0] + 1;
        // First byte goes to the shifter, next DEPTH fill the FIFO, rest drop.
        wb_read(4'h4, rd); chk("burst_status", rd, status_of(DEPTH, 1'b1, 1'b1));
        wb_write(4'h4, 32'h8, 4'h1, e);
        wb_read(4'h4, rd); chk("ovf_clear_status", rd, status_of(DEPTH, 1'b1, 1'b0));
        for (int j = 0; j < 9; j++) begin
            base = j * FRAME;
            if (j > 0) begin
                wait_cyc(f + base - 1);
                chk($sformatf("burst_stop%0d_end", j - 1), 32'(uart_tx), 32'(line_at(base - 1)));
                wait_cyc(f + base);
                chk($sformatf("burst_start%0d_nogap", j), 32'(uart_tx), 32'(line_at(base)));
            end
            pos = (cyc_n - f + 1 > base + 1) ? cyc_n - f + 1 : base + 1;
            repeat (3) begin
                pos += $urandom_range(1, 1200);
                if (pos < base + FRAME - 1) begin
                    wait_cyc(f + pos);
                    chk($sformatf("burst_line_off%0d", pos), 32'(uart_tx), 32'(line_at(pos)));
                end
            end
        end
        wait_cyc(f + 9 * FRAME - 1);
        chk("burst_last_stop", 32'(uart_tx), 32'd1);
        wait_cyc(f + 9 * FRAME);
        chk("burst_done_tx", 32'(uart_tx), 32'd1);
        wb_read(4'h4, rd); chk("burst_done_status", rd, status_of(0, 1'b0, 1'b0));
        chk("burst_dec_count", 32'(dec_q.size()), 32'd9);
        for (int i = 0; i < 9; i++)
            if (i < dec_q.size()) chk($sformatf("burst_dec%0d", i), 32'(dec_q[i]), 32'(bb[i]));

        // Interrupt
        dec_q.delete();
        wb_write(4'h8, 32'h1, 4'h1, e);
        chk("irq_at_ctrl_ack", 32'(irq), 32'd0);
        tick();
        chk("irq_after_ctrl", 32'(irq), 32'd1);
        wb_read(4'h8, rd); chk("ctrl_readback", rd, 32'd1);
        fn = 1;
        fb[0] = 8'h41;
        wb_write(4'h0, 32'h41, 4'h1, e);
        chk("irq_at_push_ack", 32'(irq), 32'd1);
        tick();
        chk("irq_after_push", 32'(irq), 32'd0);
        chk("irq_tx_start", 32'(uart_tx), 32'd0);
        f = e + 1;
        wait_cyc(f + FRAME);
        chk("irq_at_stop_end", 32'(irq), 32'd0);
        tick();
        chk("irq_after_stop", 32'(irq), 32'd1);
        chk("irq_dec_count", 32'(dec_q.size()), 32'd1);
        if (dec_q.size() > 0) chk("irq_dec_byte", 32'(dec_q[0]), 32'h41);

        // Reset in the middle of a frame
        fn = 3;
        for (int i = 0; i < 3; i++) fb[i] = 8'($urandom);
        wb_write(4'h0, 32'(fb[0]), 4'h1, e);
        f = e + 1;
        wb_write(4'h0, 32'(fb[1]), 4'h1, pos);
        wb_write(4'h0, 32'(fb[2]), 4'h1, pos);
        wait_cyc(f + 4 * DIV + 100);
        chk("midframe_line", 32'(uart_tx), 32'(line_at(4 * DIV + 100)));
        #2;
        rstn = 1'b0;
        #1;
        chk("reset_tx_immediate", 32'(uart_tx), 32'd1);
        chk("reset_irq_immediate", 32'(irq), 32'd0);
        tick(2);
        rstn = 1'b1;
        tick(2);
        wb_read(4'h4, rd); chk("after_reset_status", rd, status_of(0, 1'b0, 1'b0));
        wb_read(4'h8, rd); chk("after_reset_ctrl", rd, 32'd0);
        low_cnt = 0;
        repeat (20000) begin
            tick();
            if (uart_tx !== 1'b1) low_cnt++;
        end
        chk("after_reset_no_frames", 32'(low_cnt), 32'd0);
        chk("after_reset_irq", 32'(irq), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
